// File: rtl/mult_pkg.sv
// Shared types and sizing for the sequential shift-and-add multiplier.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      INIT = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } mult_state_t;

   localparam int unsigned PROD_W = 16;
   localparam int unsigned OPND_W = PROD_W / 2;

   function automatic int unsigned half_width(input int unsigned n);
      return n / 2;
   endfunction

endpackage

// File: rtl/mult_step.sv
// One add-and-shift step: conditionally add M into the high half, then shift {carry, A, Q} right.
module mult_step #(
   parameter int unsigned W = 8
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] q_i,
   input  logic [W-1:0] m_i,
   output logic [W-1:0] hi_o,
   output logic [W-1:0] lo_o
);

   logic [W:0] sum_s;

   // The carry in sum_s[W] becomes the new MSB of the high half.
   always_comb begin
      sum_s = {1'b0, a_i} + (q_i[0] ? {1'b0, m_i} : {(W+1){1'b0}});
      hi_o  = sum_s[W:1];
      lo_o  = {sum_s[0], q_i[W-1:1]};
   end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencer driving an external {A,Q} product register through an 8x8 (N/2 x N/2) shift-and-add multiply.
module mult_seq_ctrl
   import mult_pkg::*;
#(
   parameter int unsigned N = PROD_W
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             start,
   input  logic [N/2-1:0]   multiplicand,
   input  logic [N/2-1:0]   multiplier,
   input  logic [N-1:0]     prod,
   output logic [N/2-1:0]   inh,
   output logic [N/2-1:0]   inl,
   output logic             loadh,
   output logic             loadl,
   output logic             busy,
   output logic             done
);

   localparam int unsigned W  = half_width(N);
   localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

   mult_state_t   state_q;
   logic [CW-1:0] cnt_q;
   logic [W-1:0]  mcand_q;
   logic [W-1:0]  mplier_q;
   logic          busy_q;
   logic          done_q;
   logic [W-1:0]  step_hi_s;
   logic [W-1:0]  step_lo_s;

   mult_step #(.W(W)) u_step (
      .a_i  (prod[N-1:W]),
      .q_i  (prod[W-1:0]),
      .m_i  (mcand_q),
      .hi_o (step_hi_s),
      .lo_o (step_lo_s)
   );

   // Sequencer FSM; busy/done are registered alongside the state they describe.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state_q  <= IDLE;
         cnt_q    <= {CW{1'b0}};
         mcand_q  <= {W{1'b0}};
         mplier_q <= {W{1'b0}};
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  mcand_q  <= multiplicand;
                  mplier_q <= multiplier;
                  state_q  <= INIT;
                  busy_q   <= 1'b1;
               end else begin
                  state_q  <= IDLE;
               end
            end
            INIT: begin
               state_q <= RUN;
               cnt_q   <= {CW{1'b0}};
               busy_q  <= 1'b1;
            end
            RUN: begin
               if (cnt_q == CNT_LAST) begin
                  state_q <= DONE;
                  cnt_q   <= {CW{1'b0}};
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  cnt_q   <= cnt_q + CW'(1);
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= {CW{1'b0}};
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   // Product register inputs are combinational so it steps on the same edge as the FSM.
   always_comb begin
      inh   = {W{1'b0}};
      inl   = {W{1'b0}};
      loadh = 1'b0;
      loadl = 1'b0;
      case (state_q)
         INIT: begin
            inl   = mplier_q;
            loadh = 1'b1;
            loadl = 1'b1;
         end
         RUN: begin
            inh   = step_hi_s;
            inl   = step_lo_s;
            loadh = 1'b1;
            loadl = 1'b1;
         end
         default: begin
            inh   = {W{1'b0}};
            inl   = {W{1'b0}};
            loadh = 1'b0;
            loadl = 1'b0;
         end
      endcase
   end

   assign busy = busy_q;
   assign done = done_q;

endmodule
